// File: rtl/reg_intercon_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : reg_intercon_pkg                                           |
// | Purpose  : Shared types and constants for the register interconnect.  |
// |            FSM state encoding, error cause codes, error read data     |
// |            pattern and an index-width helper.                         |
// | Ports    : none (package)                                             |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
package reg_intercon_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE    = 2'd0,
      CAUSE_DECODE  = 2'd1,
      CAUSE_TIMEOUT = 2'd2,
      CAUSE_SLAVE   = 2'd3
   } cause_e;

   // Wide enough for any practical data width; users take [DW-1:0].
   localparam logic [1023:0] ERR_RDATA = '1;

   // Bits needed to hold an index 0..n-1 (never less than one bit).
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_addr_decode.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : reg_addr_decode                                            |
// | Purpose  : Combinational BASE/MASK address matcher with lowest-index  |
// |            priority. Only the low DECODE_BITS address bits take part. |
// | Ports    : addr_i  - byte address to decode                          |
// |            match_o - one-hot winning slave (zero on miss)             |
// |            idx_o   - index of winning slave                           |
// |            hit_o   - at least one slave matched                       |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module reg_addr_decode
   import reg_intercon_pkg::*;
#(
   parameter int                   NSLAVE      = 4,
   parameter int                   AW          = 32,
   parameter int                   DECODE_BITS = 30,
   parameter logic [NSLAVE*AW-1:0] BASE        = '0,
   parameter logic [NSLAVE*AW-1:0] MASK        = '0,
   parameter int                   IW          = idx_width(NSLAVE)
) (
   input  logic [AW-1:0]     addr_i,
   output logic [NSLAVE-1:0] match_o,
   output logic [IW-1:0]     idx_o,
   output logic              hit_o
);

   logic [AW-1:0]     dec_mask;
   logic [NSLAVE-1:0] raw;

   for (genvar b = 0; b < AW; b++) begin : g_dmask
      assign dec_mask[b] = (b < DECODE_BITS);
   end

   for (genvar i = 0; i < NSLAVE; i++) begin : g_match
      assign raw[i] = ~|((addr_i ^ BASE[i*AW +: AW]) & MASK[i*AW +: AW] & dec_mask);
   end

   // Isolate the lowest set bit so overlapping windows resolve to one slave.
   assign match_o = raw & ~(raw - NSLAVE'(1));
   assign hit_o   = |raw;

   always_comb begin
      idx_o = '0;
      for (int i = NSLAVE - 1; i >= 0; i--) begin
         if (raw[i]) begin
            idx_o = IW'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_intercon.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | Module   : reg_intercon                                               |
// | Purpose  : Single-master, N-slave register interconnect. Decodes and  |
// |            latches a bridge request, forwards it to one slave, waits  |
// |            for the ack with a timeout, and records error status.      |
// | Ports    : clk, rstn                    - clock, async low reset     |
// |            out_req/wr/addr/wstrb/wdata  - master request             |
// |            out_ack/err/rdata            - master completion          |
// |            s_req/ack/err/rdata          - per-slave handshake        |
// |            s_addr/wdata/wstrb/wr        - shared latched request     |
// |            err_clr, err_cause/addr/count - error status              |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module reg_intercon
   import reg_intercon_pkg::*;
#(
   parameter int                   NSLAVE      = 4,
   parameter int                   AW          = 32,
   parameter int                   DW          = 32,
   parameter int                   DECODE_BITS = 30,
   parameter logic [NSLAVE*AW-1:0] BASE        = {NSLAVE{32'h0}},
   parameter logic [NSLAVE*AW-1:0] MASK        = {NSLAVE{32'h3FFFFF00}},
   parameter int                   TIMEOUT     = 1024
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 out_req,
   input  logic                 out_wr,
   input  logic [AW-1:0]        out_addr,
   input  logic [DW/8-1:0]      out_wstrb,
   input  logic [DW-1:0]        out_wdata,
   output logic                 out_ack,
   output logic                 out_err,
   output logic [DW-1:0]        out_rdata,
   output logic [NSLAVE-1:0]    s_req,
   input  logic [NSLAVE-1:0]    s_ack,
   input  logic [NSLAVE-1:0]    s_err,
   input  logic [NSLAVE*DW-1:0] s_rdata,
   output logic [AW-1:0]        s_addr,
   output logic [DW-1:0]        s_wdata,
   output logic [DW/8-1:0]      s_wstrb,
   output logic                 s_wr,
   input  logic                 err_clr,
   output logic [1:0]           err_cause,
   output logic [AW-1:0]        err_addr,
   output logic [15:0]          err_count
);

   localparam int IW = idx_width(NSLAVE);
   localparam int TW = idx_width(TIMEOUT);

   state_e              state_q;
   logic [IW-1:0]       sel_q;
   logic [TW-1:0]       timer_q;
   logic [NSLAVE-1:0]   s_req_q;
   logic [AW-1:0]       s_addr_q;
   logic [DW-1:0]       s_wdata_q;
   logic [DW/8-1:0]     s_wstrb_q;
   logic                s_wr_q;
   logic                out_ack_q;
   logic                out_err_q;
   logic [DW-1:0]       out_rdata_q;
   cause_e              err_cause_q;
   logic [AW-1:0]       err_addr_q;
   logic [15:0]         err_count_q;

   logic [NSLAVE-1:0]   dec_match;
   logic [IW-1:0]       dec_idx;
   logic                dec_hit;
   logic                sel_ack;
   logic                sel_err;
   logic [DW-1:0]       sel_rdata;
   logic                timeout_fire;
   logic                err_evt_d;
   cause_e              err_cause_d;
   logic [AW-1:0]       err_addr_d;

   reg_addr_decode #(
      .NSLAVE      (NSLAVE),
      .AW          (AW),
      .DECODE_BITS (DECODE_BITS),
      .BASE        (BASE),
      .MASK        (MASK),
      .IW          (IW)
   ) u_decode (
      .addr_i  (out_addr),
      .match_o (dec_match),
      .idx_o   (dec_idx),
      .hit_o   (dec_hit)
   );

   // Only the selected slave's handshake is looked at; stray acks drop out here.
   assign sel_ack   = s_ack[sel_q];
   assign sel_err   = s_err[sel_q];
   assign sel_rdata = s_rdata[sel_q*DW +: DW];

   // Timer reads k in the k-th cycle after s_req, so firing at TIMEOUT-1
   // places out_ack exactly TIMEOUT cycles after the s_req cycle.
   assign timeout_fire = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

   always_comb begin
      err_evt_d   = 1'b0;
      err_cause_d = CAUSE_NONE;
      err_addr_d  = s_addr_q;
      case (state_q)
         IDLE: begin
            if (out_req && !dec_hit) begin
               err_evt_d   = 1'b1;
               err_cause_d = CAUSE_DECODE;
               err_addr_d  = out_addr;
            end
         end
         WAIT: begin
            if (sel_ack) begin
               if (sel_err) begin
                  err_evt_d   = 1'b1;
                  err_cause_d = CAUSE_SLAVE;
               end
            end else if (timeout_fire) begin
               err_evt_d   = 1'b1;
               err_cause_d = CAUSE_TIMEOUT;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         timer_q     <= '0;
         s_req_q     <= '0;
         s_addr_q    <= '0;
         s_wdata_q   <= '0;
         s_wstrb_q   <= '0;
         s_wr_q      <= 1'b0;
         out_ack_q   <= 1'b0;
         out_err_q   <= 1'b0;
         out_rdata_q <= '0;
      end else begin
         out_ack_q <= 1'b0;
         s_req_q   <= '0;
         case (state_q)
            IDLE: begin
               if (out_req) begin
                  if (dec_hit) begin
                     s_addr_q  <= out_addr;
                     s_wdata_q <= out_wdata;
                     s_wstrb_q <= out_wstrb;
                     s_wr_q    <= out_wr;
                     sel_q     <= dec_idx;
                     timer_q   <= '0;
                     s_req_q   <= dec_match;
                     state_q   <= WAIT;
                  end else begin
                     out_ack_q   <= 1'b1;
                     out_err_q   <= 1'b1;
                     out_rdata_q <= ERR_RDATA[DW-1:0];
                  end
               end
            end
            WAIT: begin
               if (sel_ack) begin
                  out_ack_q   <= 1'b1;
                  out_err_q   <= sel_err;
                  out_rdata_q <= sel_rdata;
                  state_q     <= IDLE;
               end else if (timeout_fire) begin
                  out_ack_q   <= 1'b1;
                  out_err_q   <= 1'b1;
                  out_rdata_q <= ERR_RDATA[DW-1:0];
                  state_q     <= IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // A new error takes precedence over a coincident clear, restarting the count at 1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_cause_q <= CAUSE_NONE;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else if (err_evt_d) begin
         err_cause_q <= err_cause_d;
         err_addr_q  <= err_addr_d;
         if (err_clr) begin
            err_count_q <= 16'd1;
         end else if (err_count_q != 16'hFFFF) begin
            err_count_q <= err_count_q + 16'd1;
         end
      end else if (err_clr) begin
         err_cause_q <= CAUSE_NONE;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end
   end

   assign out_ack   = out_ack_q;
   assign out_err   = out_err_q;
   assign out_rdata = out_rdata_q;
   assign s_req     = s_req_q;
   assign s_addr    = s_addr_q;
   assign s_wdata   = s_wdata_q;
   assign s_wstrb   = s_wstrb_q;
   assign s_wr      = s_wr_q;
   assign err_cause = err_cause_q;
   assign err_addr  = err_addr_q;
   assign err_count = err_count_q;

endmodule
`default_nettype wire
